mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_if.sv | 34 +++
 rtl/mem_stage_lsu.sv | 148 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Memory-stage LSU signal bundle: pipeline controls in, data-memory bus, writeback result and stall/fault out.
// master = the LSU itself, slave = pipeline register plus data memory around it.
interface mem_stage_lsu_if;
    logic        mem_write_m_i;
    logic        mem_read_m_i;
    logic [2:0]  funct3_m_i;
    logic [31:0] alu_result_m_i;
    logic [31:0] write_data_m_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] read_data_m_o;
    logic        stall_m_o;
    logic        misaligned_o;

    modport master (
        input  mem_write_m_i, mem_read_m_i, funct3_m_i, alu_result_m_i, write_data_m_i,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output read_data_m_o, stall_m_o, misaligned_o
    );

    modport slave (
        output mem_write_m_i, mem_read_m_i, funct3_m_i, alu_result_m_i, write_data_m_i,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  read_data_m_o, stall_m_o, misaligned_o
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32 memory-stage LSU: req/gnt/rvalid data-memory handshake, store lane steering, load extension.
// Store 3 cycles min, load 4 min; stalls the pipeline until the bus grants/responds, faults bypass the bus.
module mem_stage_lsu (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_stage_lsu_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access, is_store, legal, misal, ok;
    logic [1:0]  off_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access   = bus.mem_write_m_i | bus.mem_read_m_i;
    assign is_store = bus.mem_write_m_i;
    assign off_in   = bus.alu_result_m_i[1:0];

    always_comb begin
        legal    = 1'b0;
        misal    = 1'b0;
        be_in    = 4'b1111;
        wdata_in = bus.write_data_m_i;
        case (bus.funct3_m_i)
            3'b000: legal = 1'b1;
            3'b001: legal = 1'b1;
            3'b010: legal = 1'b1;
            3'b100: legal = ~is_store;
            3'b101: legal = ~is_store;
            default: legal = 1'b0;
        endcase
        case (bus.funct3_m_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{bus.write_data_m_i[7:0]}};
            end
            2'b01: begin
                misal    = off_in[0];
                be_in    = 4'b0011 << off_in;
                wdata_in = {2{bus.write_data_m_i[15:0]}};
            end
            default: misal = |off_in;
        endcase
    end

    assign ok = access & legal & ~misal;

    assign ld_byte = bus.dmem_rdata_i[{off_q, 3'b000} +: 8];
    assign ld_half = bus.dmem_rdata_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = bus.dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (ok) begin
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {bus.alu_result_m_i[31:2], 2'b00};
                    be_d    = be_in;
                    wdata_d = wdata_in;
                    f3_d    = bus.funct3_m_i;
                    off_d   = off_in;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.dmem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                // rvalid only matters here; stray responses in other states are dropped
                if (bus.dmem_rvalid_i) begin
                    rdata_d = ld_ext;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.dmem_req_o    = req_q;
    assign bus.dmem_we_o     = we_q;
    assign bus.dmem_addr_o   = addr_q;
    assign bus.dmem_be_o     = be_q;
    assign bus.dmem_wdata_o  = wdata_q;
    assign bus.read_data_m_o = rdata_q;

    // Reset gates the decode so every output reads zero while rst_i is held
    assign bus.stall_m_o    = ~rst_i & (((state_q == IDLE) & ok) | (state_q == REQ) | (state_q == WAIT));
    assign bus.misaligned_o = ~rst_i & (state_q == IDLE) & access & ~ok;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus random bench for mem_stage_lsu against a size/offset arithmetic reference model.
module tb_mem_stage_lsu;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] rd_exp = 32'h0;

    mem_stage_lsu_if bus ();
    mem_stage_lsu dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = m_size(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = m_size(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = m_size(f3);
        logic [31:0] mask, v;
        if (n == 4) return rd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * (a % 4))) & mask;
        if (f3 < 3'd4 && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.mem_write_m_i  = 1'b0;
        bus.mem_read_m_i   = 1'b0;
        bus.funct3_m_i     = 3'b000;
        bus.alu_result_m_i = 32'h0;
        bus.write_data_m_i = 32'h0;
    endtask

    // Called just after a rising edge with the LSU in IDLE; returns just after the edge that leaves DONE/IDLE.
    task automatic do_access(input bit we, input bit re, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata, input int gd, input int rdl);
        bit st = we;
        bit good = m_legal(st, f3) && (addr % m_size(f3) == 0);
        bus.mem_write_m_i  = we;
        bus.mem_read_m_i   = re;
        bus.funct3_m_i     = f3;
        bus.alu_result_m_i = addr;
        bus.write_data_m_i = wd;
        @(negedge clk_i);
        if (!good) begin
            chk("fault_pulse", 32'(bus.misaligned_o), 32'd1);
            chk("fault_stall", 32'(bus.stall_m_o), 32'd0);
            chk("fault_req", 32'(bus.dmem_req_o), 32'd0);
            @(posedge clk_i); #1;
            clear_inputs();
            @(negedge clk_i);
            chk("fault_gone", 32'(bus.misaligned_o), 32'd0);
            chk("fault_noreq", 32'(bus.dmem_req_o), 32'd0);
            @(posedge clk_i); #1;
            return;
        end
        chk("idle_stall", 32'(bus.stall_m_o), 32'd1);
        chk("idle_mis", 32'(bus.misaligned_o), 32'd0);
        chk("idle_req", 32'(bus.dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
        for (int k = 0; k <= gd; k++) begin
            bus.dmem_gnt_i = (k == gd);
            @(negedge clk_i);
            chk("req_req", 32'(bus.dmem_req_o), 32'd1);
            chk("req_stall", 32'(bus.stall_m_o), 32'd1);
            chk("req_addr", bus.dmem_addr_o, addr & 32'hFFFF_FFFC);
            chk("req_we", 32'(bus.dmem_we_o), 32'(st));
            chk("req_be", 32'(bus.dmem_be_o), 32'(m_be(f3, addr)));
            if (st) chk("req_wdata", bus.dmem_wdata_o, m_wdata(f3, wd));
            @(posedge clk_i); #1;
        end
        bus.dmem_gnt_i = 1'b0;
        if (!st) begin
            for (int j = 0; j <= rdl; j++) begin
                bus.dmem_rvalid_i = (j == rdl);
                bus.dmem_rdata_i  = (j == rdl) ? rdata : $urandom;
                @(negedge clk_i);
                chk("wait_stall", 32'(bus.stall_m_o), 32'd1);
                chk("wait_req", 32'(bus.dmem_req_o), 32'd0);
                @(posedge clk_i); #1;
            end
            bus.dmem_rvalid_i = 1'b0;
            rd_exp = m_load(f3, addr, rdata);
        end
        @(negedge clk_i);
        chk("done_stall", 32'(bus.stall_m_o), 32'd0);
        chk("done_req", 32'(bus.dmem_req_o), 32'd0);
        chk("done_rdata", bus.read_data_m_o, rd_exp);
        @(posedge clk_i); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = 32'h0;
        #2;
        chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
        chk("rst_addr", bus.dmem_addr_o, 32'h0);
        chk("rst_be", 32'(bus.dmem_be_o), 32'd0);
        chk("rst_wdata", bus.dmem_wdata_o, 32'h0);
        chk("rst_rdata", bus.read_data_m_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_nostall", 32'(bus.stall_m_o), 32'd0);
        chk("idle_nomis", 32'(bus.misaligned_o), 32'd0);
        @(posedge clk_i); #1;

        do_access(1, 0, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_access(0, 1, 3'b000, 32'h2003, 32'h0, 32'h80FF_FF7F, 2, 0);
        chk("lb_value", bus.read_data_m_o, 32'hFFFF_FF80);
        do_access(0, 1, 3'b100, 32'h2003, 32'h0, 32'h80FF_FF7F, 2, 1);
        chk("lbu_value", bus.read_data_m_o, 32'h0000_0080);
        do_access(1, 0, 3'b001, 32'h3002, 32'h0000_1234, 32'h0, 1, 0);
        chk("sh_be", 32'(bus.dmem_be_o), 32'hC);
        chk("sh_wdata", bus.dmem_wdata_o, 32'h1234_1234);
        do_access(0, 1, 3'b101, 32'h3002, 32'h0, 32'hABCD_0000, 0, 0);
        chk("lhu_value", bus.read_data_m_o, 32'h0000_ABCD);
        do_access(0, 1, 3'b010, 32'h4001, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, 3'b011, 32'h4000, 32'h0, 32'h0, 0, 0);
        do_access(1, 1, 3'b010, 32'h6000, 32'h5555_AAAA, 32'h0, 0, 0);
        chk("both_rdata_kept", bus.read_data_m_o, 32'h0000_ABCD);

        // Reset while a load waits for its response
        bus.mem_read_m_i   = 1'b1;
        bus.funct3_m_i     = 3'b010;
        bus.alu_result_m_i = 32'h5000;
        @(posedge clk_i); #1;
        bus.dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        bus.dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_stall", 32'(bus.stall_m_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.dmem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall_m_o), 32'd0);
        chk("mid_rst_rdata", bus.read_data_m_o, 32'h0);
        chk("mid_rst_addr", bus.dmem_addr_o, 32'h0);
        clear_inputs();
        @(negedge clk_i);
        rst_i  = 1'b0;
        rd_exp = 32'h0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h1234_5678;
        @(posedge clk_i); #1;
        bus.dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("stray_rvalid", bus.read_data_m_o, 32'h0);
        chk("post_rst_stall", 32'(bus.stall_m_o), 32'd0);
        @(posedge clk_i); #1;
        do_access(0, 1, 3'b010, 32'h5000, 32'h0, 32'hCAFE_F00D, 1, 1);

        for (int i = 0; i < 60; i++) begin
            bit we = 1'($urandom);
            bit re = we ? 1'($urandom) : 1'b1;
            do_access(we, re, 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
